// File: rtl/ascon128_decrypt_core.sv
// ascon128_decrypt_core: Ascon-128 decrypt + tag verify (start/done, busy; key/nonce/ad/ct/tag_in in, pt/tag_ok out, pt released only on tag match)
module ascon128_decrypt_core #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [255:0] ad,
  input  logic [255:0] ct,
  input  logic [127:0] tag_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] pt,
  output logic         tag_ok
);
  localparam logic [63:0] PAD = 64'h8000000000000000;
  typedef enum logic [2:0] {IDLE, INIT, AD, CT, FINAL, CHECK} state_t;
  state_t state;
  logic [3:0] rnd, rc_idx;
  logic [2:0] blk;
  logic [319:0] s, rin, rout;
  logic [255:0] ad_r, ct_r, pt_acc;
  logic [127:0] tag_r;
  logic match, last_a, last_b;
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  function automatic logic [319:0] round_fn(input logic [319:0] si, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = si[319:256];
    x1 = si[255:192];
    x2 = si[191:128] ^ {56'h0, c};
    x3 = si[127:64];
    x4 = si[63:0];
    x0 ^= x4;
    x4 ^= x3;
    x2 ^= x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 ^= t1;
    x1 ^= t2;
    x2 ^= t3;
    x3 ^= t4;
    x4 ^= t0;
    x1 ^= x0;
    x0 ^= x4;
    x3 ^= x2;
    x2 = ~x2;
    return {x0 ^ ror(x0, 19) ^ ror(x0, 28), x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x2 ^ ror(x2, 1) ^ ror(x2, 6), x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x4 ^ ror(x4, 7) ^ ror(x4, 41)};
  endfunction
  always_comb begin
    last_a = rnd == 4'(ROUNDS_A - 1);
    last_b = rnd == 4'(ROUNDS_B - 1);
    rc_idx = (state == AD || state == CT) ? rnd + 4'(ROUNDS_A - ROUNDS_B) : rnd;
    rin = s ^ ((state == AD && rnd == '0) ? {ad_r[255:192], 256'h0} : 320'h0)
            ^ ((state == FINAL && rnd == '0) ? {PAD, key, 128'h0} : 320'h0);
    if (state == CT && rnd == '0) rin[319:256] = ct_r[255:192];
    rout = round_fn(rin, 8'hf0 - 8'(rc_idx) * 8'h0f);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd <= '0;
      blk <= '0;
      s <= '0;
      ad_r <= '0;
      ct_r <= '0;
      pt_acc <= '0;
      tag_r <= '0;
      match <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pt <= '0;
      tag_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          s <= {IV, key, nonce};
          ad_r <= ad;
          ct_r <= ct;
          tag_r <= tag_in;
          pt <= '0;
          tag_ok <= 1'b0;
          busy <= 1'b1;
          rnd <= '0;
          blk <= '0;
          state <= INIT;
        end
        INIT: begin
          s <= last_a ? rout ^ {192'h0, key} : rout;
          rnd <= last_a ? '0 : rnd + 4'd1;
          if (last_a) state <= AD;
        end
        AD: begin
          s <= (last_b && blk == 3'd4) ? rout ^ 320'h1 : rout;
          if (rnd == '0) ad_r <= {ad_r[191:0], PAD};
          rnd <= last_b ? '0 : rnd + 4'd1;
          if (last_b) blk <= blk == 3'd4 ? '0 : blk + 3'd1;
          if (last_b && blk == 3'd4) state <= CT;
        end
        CT: begin
          s <= rout;
          if (rnd == '0) begin
            pt_acc <= {pt_acc[191:0], s[319:256] ^ ct_r[255:192]};
            ct_r <= {ct_r[191:0], 64'h0};
          end
          rnd <= last_b ? '0 : rnd + 4'd1;
          if (last_b) blk <= blk == 3'd3 ? '0 : blk + 3'd1;
          if (last_b && blk == 3'd3) state <= FINAL;
        end
        FINAL: begin
          s <= rout;
          rnd <= last_a ? '0 : rnd + 4'd1;
          if (last_a) state <= CHECK;
        end
        CHECK: begin
          if (rnd == '0) begin
            match <= ~|(s[127:0] ^ key ^ tag_r);
            rnd <= 4'd1;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
            tag_ok <= match;
            pt <= match ? pt_acc : '0;
            rnd <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon128_decrypt_core.sv
// tb_ascon128_decrypt_core: directed round-trip checks against a reference Ascon-128 encryptor
module tb_ascon128_decrypt_core;
  localparam logic [63:0] IV = 64'h80400c0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;
  localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [255:0] A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] P = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
  localparam logic [255:0] P2 = 256'hdeadbeef0123456789abcdef00112233445566778899aabbccddeeff13579bdf;
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic clk = 1'b0;
  logic rst, start, busy, done, tag_ok;
  logic [127:0] key, nonce, tag_in, t0, t1;
  logic [255:0] ad, ct, pt, c0, c1;
  int checks = 0;
  int failures = 0;
  int lat, ndone;
  ascon128_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .ad(ad), .ct(ct),
    .tag_in(tag_in), .busy(busy), .done(done), .pt(pt), .tag_ok(tag_ok)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  function automatic logic [319:0] perm(input logic [319:0] si, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0] o;
    for (int w = 0; w < 5; w++) x[w] = si[319 - 64 * w -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] ^= 64'(240 - 15 * r);
      for (int b = 0; b < 64; b++) begin
        o = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int w = 0; w < 5; w++) y[w][b] = o[4 - w];
      end
      x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
      x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
      x[2] = y[2] ^ rot(y[2], 1) ^ rot(y[2], 6);
      x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
      x[4] = y[4] ^ rot(y[4], 7) ^ rot(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction
  task automatic ascon_enc(input logic [127:0] k, input logic [127:0] n, input logic [255:0] a,
                           input logic [255:0] p, output logic [255:0] c, output logic [127:0] t);
    logic [319:0] st;
    st = perm({IV, k, n}, 12) ^ {192'h0, k};
    for (int i = 0; i < 4; i++) begin
      st[319:256] ^= a[255 - 64 * i -: 64];
      st = perm(st, 6);
    end
    st[319:256] ^= PAD;
    st = perm(st, 6);
    st[0] = ~st[0];
    for (int i = 0; i < 4; i++) begin
      st[319:256] ^= p[255 - 64 * i -: 64];
      c[255 - 64 * i -: 64] = st[319:256];
      st = perm(st, 6);
    end
    st[319:256] ^= PAD;
    st[255:128] ^= k;
    st = perm(st, 12);
    t = st[127:0] ^ k;
  endtask
  task automatic launch(input logic [127:0] n, input logic [255:0] c, input logic [127:0] t);
    nonce = n;
    ct = c;
    tag_in = t;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int pa, input int pb, output int l);
    l = 0;
    while (!done && l < 200) begin
      start = (l == pa || l == pb);
      @(posedge clk);
      #1 l++;
    end
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    key = K;
    nonce = K;
    ad = A;
    ct = '0;
    tag_in = '0;
    ascon_enc(K, K, A, P, c0, t0);
    ascon_enc(K, N2, A, P2, c1, t1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pt", pt, 0);
    chk("rst_tag_ok", tag_ok, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    launch(K, c0, t0);
    wait_done(-1, -1, lat);
    chk("rt_lat", lat, 80);
    chk("rt_tag_ok", tag_ok, 1);
    chk("rt_pt", pt, P);
    chk("rt_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("rt_pulse", done, 0);
    chk("rt_hold", pt, P);
    launch(K, c0 ^ 256'h1, t0);
    wait_done(-1, -1, lat);
    chk("ct_flip_lat", lat, 80);
    chk("ct_flip_tag_ok", tag_ok, 0);
    chk("ct_flip_pt", pt, 0);
    @(posedge clk);
    #1;
    launch(K, c0, t0 ^ {1'b1, 127'h0});
    wait_done(-1, -1, lat);
    chk("tag_flip_tag_ok", tag_ok, 0);
    chk("tag_flip_pt", pt, 0);
    @(posedge clk);
    #1;
    launch(K, c0, t0);
    wait_done(5, 40, lat);
    chk("busy_start_lat", lat, 80);
    chk("busy_start_tag_ok", tag_ok, 1);
    chk("busy_start_pt", pt, P);
    @(posedge clk);
    #1;
    chk("busy_start_idle", busy, 0);
    launch(K, c0, t0);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (90) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", busy, 0);
    launch(K, c0, t0);
    wait_done(-1, -1, lat);
    chk("restart_lat", lat, 80);
    chk("restart_tag_ok", tag_ok, 1);
    chk("restart_pt", pt, P);
    @(posedge clk);
    #1;
    launch(K, c0, t0);
    wait_done(-1, -1, lat);
    chk("b2b_a_lat", lat, 80);
    chk("b2b_a_pt", pt, P);
    nonce = N2;
    ct = c1;
    tag_in = t1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_clear_pt", pt, 0);
    chk("b2b_clear_tag_ok", tag_ok, 0);
    chk("b2b_busy", busy, 1);
    wait_done(-1, -1, lat);
    chk("b2b_gap", lat + 1, 81);
    chk("b2b_b_tag_ok", tag_ok, 1);
    chk("b2b_b_pt", pt, P2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
